regfile_x: RTL and testbench
============================

Name: regfile_x

Overview:
- Next-generation CPU register file: 16 registers R0..R15 with address width parametrised up to MSP430X 20-bit.
- All updates happen on one clock edge with a fixed priority.
- Includes the constant generator (R2/R3), indirect autoincrement and SR flag update.
- Adds a multi-register PUSHM/POPM sequencer that moves a block of registers to or from the stack one register per memory handshake.
- Sits between the decoder/control FSM and the memory bus interface.

Parameters:
AW, 20, register/address width in bits (legal 16..20)
SLOT_BYTES, 2, SP step per register for PUSHM/POPM (2 or 4)
RESET_PC, 0, PC (R0) value after reset
RESET_SP, 0, SP (R1) value after reset

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  reset, synchronous, active-high
mo  in  2  memory op: 0 NOP, 1 NEXT_INSTR, 2 OFFSET, 3 SP_PREDEC
branch_en  in  1  load PC from branch_addr
branch_addr  in  AW  branch target
sr_we  in  1  update SR Z/V/N/C from flag inputs
z_in, v_in, n_in, c_in  in  1 each  flags from function unit
src_a, dst_a  in  4 each  source/destination register index
as  in  2  source addressing mode
ad  in  1  destination addressing mode
one_op  in  1  single-operand instruction: dst uses as, indirect uses dst_a
inc_src, inc_dst  in  1 each  autoincrement request
bw  in  1  byte op: increment 1, else 2
indirect  in  1  drive mab from the selected register
res_a  in  4  writeback register index
rw  in  1  writeback enable
data_in  in  AW  writeback data
mreg_start  in  1  start PUSHM/POPM (sampled in IDLE only)
mreg_pop  in  1  1 POPM, 0 PUSHM
mreg_reg  in  4  highest register of the block
mreg_cnt  in  4  register count minus 1
mem_rdy  in  1  memory completes the current access this cycle
mem_rdata  in  AW  POPM read data
mem_we, mem_re  out  1 each  sequencer write/read strobe
mem_wdata  out  AW  PUSHM write data
mreg_busy  out  1  sequencer not IDLE
mreg_done  out  1  one-cycle completion pulse
pc, sp  out  AW each  R0, R1
rsrc, rdst  out  AW each  operands, constant generator applied
mab  out  AW  memory address bus
z_cur, v_cur, n_cur, c_cur  out  1 each  SR flags

Behaviour:
- Reset (posedge with reset=1):
  - PC=RESET_PC with bit0 cleared; SP=RESET_SP with bit0 cleared; all other registers 0.
  - Sequencer goes to IDLE; mreg_busy, mreg_done, mem_we, mem_re are 0.
  - Reset mid-sequence aborts it with no further register or SP change.
- Arithmetic is modulo 2^AW.
- Writes to R0/R1 force bit0=0. Writes to R2 keep bits [8:0] and zero the rest. R3 always reads 0.
- Per-register priority, highest first: reset > sequencer > rw writeback > branch_en (PC) > sr_we (SR flag bits) > mo/autoincrement.
  - rw to SR overrides sr_we in the same cycle.
  - rw to a register being autoincremented wins.
- mo=NEXT_INSTR or OFFSET: PC += 2. mo=SP_PREDEC: SP -= 2. Branch overrides the PC increment.
- inc_src/inc_dst: register += (bw ? 1 : 2). If src_a == dst_a with both set, increment once.
- Constant generator (src, and dst when one_op), per as:
  - R2: 00 reads R2; 01 gives 0; 10 gives 4; 11 gives 8.
  - R3: 00 gives 0; 01 gives 1; 10 gives 2; 11 gives all-ones (AW bits).
  - Two-operand dst uses ad: R2/ad=1 gives 0; R3/ad=1 gives 1.
- Reads are combinational, showing register contents before the edge.
- mab, combinational, first match wins:
  - mreg_busy: SP.
  - mo in {NEXT_INSTR, OFFSET}: PC.
  - indirect: R[one_op ? dst_a : src_a].
  - otherwise 0.
- Sequencer FSM states: IDLE, PUSH_DEC, PUSH_WR, POP_RD.
  - IDLE, mreg_start=1: latch idx, count, dir.
    - PUSHM: idx=mreg_reg, go to PUSH_DEC.
    - POPM: idx=mreg_reg-mreg_cnt (mod 16), go to POP_RD.
  - PUSH_DEC: SP -= SLOT_BYTES, go to PUSH_WR.
  - PUSH_WR: mem_we=1, mem_wdata=R[idx]. Hold until mem_rdy.
    - On mem_rdy with count=0: mreg_done pulse, go to IDLE.
    - On mem_rdy otherwise: idx--, count--, go to PUSH_DEC.
  - POP_RD: mem_re=1. Hold until mem_rdy, then R[idx]=mem_rdata (write masking rules apply) and SP += SLOT_BYTES.
    - If count=0: mreg_done pulse, go to IDLE.
    - Otherwise: idx++, count--, stay in POP_RD.
  - While busy: mreg_start is ignored. rw/branch/mo/inc to registers touched by the sequencer lose; others proceed.
  - POPM into R1: the loaded value takes effect and the SP increment is skipped that step.

Optional Feature:
REGFILE_MREG_EN defined:
- Sequencer present as described.

REGFILE_MREG_EN undefined:
- No FSM. mreg_busy, mreg_done, mem_we, mem_re tied 0; mem_wdata = 0.
- mreg_* and mem_* inputs ignored; mab never selects SP.

Test Plan:
- reset with RESET_PC=0x4401, RESET_SP=0x2400 -> pc=0x4400, sp=0x2400, R4..R15=0, mreg_busy=0.
- mo=NEXT_INSTR with branch_en=1, branch_addr=0x1234 same cycle -> pc=0x1234; next cycle mo=NEXT_INSTR alone -> pc=0x1236.
- AW=20, R5=0xFFFFF, inc_src, bw=0, src_a=5 -> R5=0x00001. Then as=11, src_a=3 -> rsrc=0xFFFFF.
- PUSHM mreg_reg=10, mreg_cnt=2, SP=0x2400, mem_rdy immediate -> writes R10@0x23FE, R9@0x23FC, R8@0x23FA; SP=0x23FA; mreg_done after 6 cycles.
- POPM mreg_reg=10, mreg_cnt=2, SP=0x23FA, mem_rdy delayed 2 cycles per access -> R8, R9, R10 loaded in order; SP=0x2400; mem_re held during wait.
- Reset asserted while in PUSH_WR -> next cycle IDLE, mem_we=0, SP=RESET_SP.

Source files
------------

// File: rtl/regfile_x_if.sv
// Memory-side bus of regfile_x: PUSHM/POPM strobes, write/read data and
// the address bus. The register file is master, the memory system slave.
interface regfile_x_if #(
  parameter int AW = 20
);
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mab;
  logic          mem_rdy;
  logic [AW-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_re,
    output mem_wdata,
    output mab,
    input  mem_rdy,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_re,
    input  mem_wdata,
    input  mab,
    output mem_rdy,
    output mem_rdata
  );
endinterface

// File: rtl/regfile_x.sv
// 16-entry CPU register file with constant generator, autoincrement, SR flags
// and an optional PUSHM/POPM sequencer enabled by `define REGFILE_MREG_EN.
module regfile_x #(
  parameter int AW         = 20,
  parameter int SLOT_BYTES = 2,
  parameter int RESET_PC   = 0,
  parameter int RESET_SP   = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mo,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_addr,
  input  logic          sr_we,
  input  logic          z_in,
  input  logic          v_in,
  input  logic          n_in,
  input  logic          c_in,
  input  logic [3:0]    src_a,
  input  logic [3:0]    dst_a,
  input  logic [1:0]    as,
  input  logic          ad,
  input  logic          one_op,
  input  logic          inc_src,
  input  logic          inc_dst,
  input  logic          bw,
  input  logic          indirect,
  input  logic [3:0]    res_a,
  input  logic          rw,
  input  logic [AW-1:0] data_in,
  input  logic          mreg_start,
  input  logic          mreg_pop,
  input  logic [3:0]    mreg_reg,
  input  logic [3:0]    mreg_cnt,
  regfile_x_if.master   bus,
  output logic          mreg_busy,
  output logic          mreg_done,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] rsrc,
  output logic [AW-1:0] rdst,
  output logic          z_cur,
  output logic          v_cur,
  output logic          n_cur,
  output logic          c_cur
);

  localparam logic [1:0] MO_NEXT = 2'd1;
  localparam logic [1:0] MO_OFF  = 2'd2;
  localparam logic [1:0] MO_PRE  = 2'd3;

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC) & ~AW'(1);
  localparam logic [AW-1:0] RST_SP = AW'(RESET_SP) & ~AW'(1);
  localparam logic [AW-1:0] SLOT   = AW'(SLOT_BYTES);

  logic [AW-1:0] r     [16];
  logic [AW-1:0] rNext [16];
  logic [AW-1:0] rv    [16];
  logic [AW-1:0] incStep;
  logic          seqDec;
  logic          seqPop;
  logic [3:0]    idx;

  function automatic logic [AW-1:0] wmask(
    input logic [3:0]    a,
    input logic [AW-1:0] v
  );
    unique case (1'b1)
      (a <= 4'd1): wmask = v & ~AW'(1);
      (a == 4'd2): wmask = v & AW'(9'h1FF);
      default:     wmask = v;
    endcase
  endfunction

  function automatic logic [AW-1:0] cg(
    input logic [3:0]    a,
    input logic [1:0]    m,
    input logic [AW-1:0] v
  );
    cg = v;
    if (a == 4'd2) begin
      unique case (m)
        2'd0: cg = v;
        2'd1: cg = '0;
        2'd2: cg = AW'(4);
        2'd3: cg = AW'(8);
      endcase
    end else if (a == 4'd3) begin
      unique case (m)
        2'd0: cg = '0;
        2'd1: cg = AW'(1);
        2'd2: cg = AW'(2);
        2'd3: cg = '1;
      endcase
    end
  endfunction

`ifdef REGFILE_MREG_EN
  typedef enum logic [1:0] {
    IDLE,
    PUSH_DEC,
    PUSH_WR,
    POP_RD
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [3:0] idxNext;
  logic [3:0] cnt;
  logic [3:0] cntNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (mreg_start) begin
          cntNext = mreg_cnt;
          if (mreg_pop) begin
            idxNext   = mreg_reg - mreg_cnt;
            stateNext = POP_RD;
          end else begin
            idxNext   = mreg_reg;
            stateNext = PUSH_DEC;
          end
        end
      end
      PUSH_DEC: stateNext = PUSH_WR;
      PUSH_WR: begin
        if (bus.mem_rdy) begin
          if (cnt == 4'd0) begin
            stateNext = IDLE;
          end else begin
            idxNext   = idx - 4'd1;
            cntNext   = cnt - 4'd1;
            stateNext = PUSH_DEC;
          end
        end
      end
      POP_RD: begin
        if (bus.mem_rdy) begin
          if (cnt == 4'd0) begin
            stateNext = IDLE;
          end else begin
            idxNext = idx + 4'd1;
            cntNext = cnt - 4'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mreg_busy     = (state != IDLE);
    bus.mem_we    = (state == PUSH_WR);
    bus.mem_re    = (state == POP_RD);
    bus.mem_wdata = (state == PUSH_WR) ? rv[idx] : '0;
    seqDec        = (state == PUSH_DEC);
    seqPop        = (state == POP_RD) && bus.mem_rdy;
    mreg_done     = bus.mem_rdy && (cnt == 4'd0) &&
                    (state == PUSH_WR || state == POP_RD);
  end
`else
  logic unusedMreg;

  assign unusedMreg    = ^{mreg_start, mreg_pop, mreg_reg,
                           mreg_cnt, bus.mem_rdy, bus.mem_rdata};
  assign mreg_busy     = 1'b0;
  assign mreg_done     = 1'b0;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_re    = 1'b0;
  assign bus.mem_wdata = '0;
  assign seqDec        = 1'b0;
  assign seqPop        = 1'b0;
  assign idx           = '0;
`endif

  always_comb begin
    for (int i = 0; i < 16; i++) rv[i] = r[i];
    rv[3] = '0;
  end

  assign incStep = bw ? AW'(1) : AW'(2);

  // Lowest priority is applied first; later assignments win.
  always_comb begin
    for (int i = 0; i < 16; i++) rNext[i] = r[i];
    if (mo == MO_NEXT || mo == MO_OFF)
      rNext[0] = wmask(4'd0, r[0] + AW'(2));
    if (mo == MO_PRE)
      rNext[1] = wmask(4'd1, r[1] - AW'(2));
    if (inc_src)
      rNext[src_a] = wmask(src_a, r[src_a] + incStep);
    if (inc_dst)
      rNext[dst_a] = wmask(dst_a, r[dst_a] + incStep);
    if (sr_we) begin
      rNext[2][0] = c_in;
      rNext[2][1] = z_in;
      rNext[2][2] = n_in;
      rNext[2][8] = v_in;
    end
    if (branch_en)
      rNext[0] = wmask(4'd0, branch_addr);
    if (rw)
      rNext[res_a] = wmask(res_a, data_in);
    if (mreg_busy)
      rNext[1] = r[1];
    if (seqDec)
      rNext[1] = wmask(4'd1, r[1] - SLOT);
    if (seqPop) begin
      rNext[1]   = wmask(4'd1, r[1] + SLOT);
      rNext[idx] = wmask(idx, bus.mem_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      r[0] <= RST_PC;
      r[1] <= RST_SP;
    end else begin
      for (int i = 0; i < 16; i++) r[i] <= rNext[i];
    end
  end

  assign pc    = r[0];
  assign sp    = r[1];
  assign c_cur = r[2][0];
  assign z_cur = r[2][1];
  assign n_cur = r[2][2];
  assign v_cur = r[2][8];

  assign rsrc = cg(src_a, as, rv[src_a]);

  always_comb begin
    if (one_op)
      rdst = cg(dst_a, as, rv[dst_a]);
    else if (dst_a == 4'd2 && ad)
      rdst = '0;
    else if (dst_a == 4'd3 && ad)
      rdst = AW'(1);
    else
      rdst = rv[dst_a];
  end

  always_comb begin
    unique case (1'b1)
      mreg_busy:
        bus.mab = r[1];
      (mo == MO_NEXT || mo == MO_OFF):
        bus.mab = r[0];
      indirect:
        bus.mab = rv[one_op ? dst_a : src_a];
      default:
        bus.mab = '0;
    endcase
  end

endmodule

// File: tb/tb_regfile_x.sv
// Self-checking bench for regfile_x; PUSHM/POPM traffic goes through a
// scoreboard queue, and a small memory model serves POPM reads.
module tb_regfile_x;
  localparam int AW = 20;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mo;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic          sr_we, z_in, v_in, n_in, c_in;
  logic [3:0]    src_a, dst_a;
  logic [1:0]    as;
  logic          ad, one_op, inc_src, inc_dst, bw, indirect;
  logic [3:0]    res_a;
  logic          rw;
  logic [AW-1:0] data_in;
  logic          mreg_start, mreg_pop;
  logic [3:0]    mreg_reg, mreg_cnt;
  logic          mreg_busy, mreg_done;
  logic [AW-1:0] pc, sp, rsrc, rdst;
  logic          z_cur, v_cur, n_cur, c_cur;

  int checks = 0;
  int failures = 0;

  xfer_t         expQ[$];
  logic [AW-1:0] mem [int];

  regfile_x_if #(.AW(AW)) bus();

  regfile_x #(
    .AW(AW), .SLOT_BYTES(2),
    .RESET_PC('h4401), .RESET_SP('h2400)
  ) dut (
    .clk(clk), .reset(reset), .mo(mo),
    .branch_en(branch_en), .branch_addr(branch_addr),
    .sr_we(sr_we), .z_in(z_in), .v_in(v_in),
    .n_in(n_in), .c_in(c_in),
    .src_a(src_a), .dst_a(dst_a), .as(as), .ad(ad),
    .one_op(one_op), .inc_src(inc_src), .inc_dst(inc_dst),
    .bw(bw), .indirect(indirect), .res_a(res_a), .rw(rw),
    .data_in(data_in), .mreg_start(mreg_start),
    .mreg_pop(mreg_pop), .mreg_reg(mreg_reg),
    .mreg_cnt(mreg_cnt), .bus(bus),
    .mreg_busy(mreg_busy), .mreg_done(mreg_done),
    .pc(pc), .sp(sp), .rsrc(rsrc), .rdst(rdst),
    .z_cur(z_cur), .v_cur(v_cur), .n_cur(n_cur), .c_cur(c_cur)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [AW-1:0] got,
                     input logic [AW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mo = 2'd0; branch_en = 1'b0; branch_addr = '0;
    sr_we = 1'b0; z_in = 1'b0; v_in = 1'b0;
    n_in = 1'b0; c_in = 1'b0;
    src_a = 4'd0; dst_a = 4'd0; as = 2'd0; ad = 1'b0;
    one_op = 1'b0; inc_src = 1'b0; inc_dst = 1'b0;
    bw = 1'b0; indirect = 1'b0; res_a = 4'd0;
    rw = 1'b0; data_in = '0;
    mreg_start = 1'b0; mreg_pop = 1'b0;
    mreg_reg = 4'd0; mreg_cnt = 4'd0;
    bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic writeReg(input logic [3:0] a,
                          input logic [AW-1:0] v);
    rw = 1'b1; res_a = a; data_in = v;
    tick();
    rw = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] a,
                         output logic [AW-1:0] v);
    src_a = a; as = 2'd0;
    tick();
    v = rsrc;
  endtask

  initial begin
    logic [AW-1:0] v;
    xfer_t x;
    int cyc, waitCnt, reCyc;
    logic gotDone;
    logic [3:0] idxQ[$];
    logic [3:0] expIdx;

    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst pc", pc, 20'h04400);
    chk("rst sp", sp, 20'h02400);
    chk("rst busy", AW'(mreg_busy), '0);
    chk("rst done", AW'(mreg_done), '0);
    chk("rst we", AW'(bus.mem_we), '0);
    chk("rst re", AW'(bus.mem_re), '0);
    for (int i = 4; i < 16; i++) begin
      readReg(4'(i), v);
      chk($sformatf("rst r%0d", i), v, '0);
    end

    mo = 2'd1; branch_en = 1'b1; branch_addr = 20'h01234;
    tick();
    branch_en = 1'b0;
    chk("branch pc", pc, 20'h01234);
    #1 chk("mab pc", bus.mab, 20'h01234);
    tick();
    mo = 2'd0;
    chk("next pc", pc, 20'h01236);

    writeReg(4'd5, 20'hFFFFF);
    inc_src = 1'b1; src_a = 4'd5; bw = 1'b0;
    #1 chk("pre-edge r5", rsrc, 20'hFFFFF);
    tick();
    inc_src = 1'b0;
    readReg(4'd5, v);
    chk("inc wrap r5", v, 20'h00001);
    src_a = 4'd3; as = 2'd3;
    #1 chk("cg r3 11", rsrc, 20'hFFFFF);
    as = 2'd1;
    #1 chk("cg r3 01", rsrc, 20'h00001);
    as = 2'd2;
    #1 chk("cg r3 10", rsrc, 20'h00002);
    src_a = 4'd2; as = 2'd2;
    #1 chk("cg r2 10", rsrc, 20'h00004);
    as = 2'd3;
    #1 chk("cg r2 11", rsrc, 20'h00008);
    tick();
    as = 2'd0; dst_a = 4'd3; ad = 1'b1;
    #1 chk("dst r3 ad", rdst, 20'h00001);
    dst_a = 4'd2;
    #1 chk("dst r2 ad", rdst, '0);
    one_op = 1'b1; dst_a = 4'd3; as = 2'd3;
    #1 chk("one_op r3", rdst, 20'hFFFFF);
    tick();
    idle();

    sr_we = 1'b1; z_in = 1'b1; c_in = 1'b1;
    tick();
    idle();
    chk("sr z", AW'(z_cur), 20'h1);
    chk("sr c", AW'(c_cur), 20'h1);
    chk("sr n", AW'(n_cur), '0);
    chk("sr v", AW'(v_cur), '0);
    sr_we = 1'b1;
    writeReg(4'd2, 20'hFFFFF);
    sr_we = 1'b0;
    readReg(4'd2, v);
    chk("rw over sr", v, 20'h001FF);
    chk("sr v set", AW'(v_cur), 20'h1);

    writeReg(4'd0, 20'h01235);
    chk("pc bit0", pc, 20'h01234);
    mo = 2'd3;
    tick();
    mo = 2'd0;
    chk("sp predec", sp, 20'h023FE);
    writeReg(4'd1, 20'h02401);
    chk("sp bit0", sp, 20'h02400);

    writeReg(4'd6, 20'h00010);
    inc_src = 1'b1; inc_dst = 1'b1;
    src_a = 4'd6; dst_a = 4'd6; bw = 1'b1;
    tick();
    idle();
    readReg(4'd6, v);
    chk("inc once r6", v, 20'h00011);
    indirect = 1'b1; src_a = 4'd6;
    #1 chk("mab ind src", bus.mab, 20'h00011);
    one_op = 1'b1; dst_a = 4'd5;
    #1 chk("mab ind dst", bus.mab, 20'h00001);
    tick();
    idle();

    writeReg(4'd8,  20'hA5A58);
    writeReg(4'd9,  20'h5A5A6);
    writeReg(4'd10, 20'h12340);

`ifdef REGFILE_MREG_EN
    expQ.push_back('{addr: 20'h023FE, data: 20'h12340});
    expQ.push_back('{addr: 20'h023FC, data: 20'h5A5A6});
    expQ.push_back('{addr: 20'h023FA, data: 20'hA5A58});
    bus.mem_rdy = 1'b1;
    mreg_start = 1'b1; mreg_pop = 1'b0;
    mreg_reg = 4'd10; mreg_cnt = 4'd2;
    tick();
    mreg_start = 1'b0;
    cyc = 1; gotDone = 1'b0;
    for (int k = 0; k < 20 && !gotDone; k++) begin
      if (bus.mem_we && bus.mem_rdy) begin
        if (expQ.size() == 0) begin
          chk("push extra", AW'(1), '0);
        end else begin
          x = expQ.pop_front();
          chk("push addr", bus.mab, x.addr);
          chk("push data", bus.mem_wdata, x.data);
        end
        mem[int'(bus.mab)] = bus.mem_wdata;
      end
      if (mreg_done) begin
        gotDone = 1'b1;
        chk("push cycles", AW'(cyc), 20'd6);
      end
      tick();
      cyc++;
    end
    chk("push done", AW'(gotDone), 20'h1);
    chk("push left", AW'(expQ.size()), '0);
    chk("push sp", sp, 20'h023FA);
    chk("push idle", AW'(mreg_busy), '0);
    bus.mem_rdy = 1'b0;

    writeReg(4'd8, '0);
    writeReg(4'd9, '0);
    writeReg(4'd10, '0);

    expQ.push_back('{addr: 20'h023FA, data: 20'hA5A58});
    expQ.push_back('{addr: 20'h023FC, data: 20'h5A5A6});
    expQ.push_back('{addr: 20'h023FE, data: 20'h12340});
    idxQ = '{4'd8, 4'd9, 4'd10};
    mreg_start = 1'b1; mreg_pop = 1'b1;
    mreg_reg = 4'd10; mreg_cnt = 4'd2;
    tick();
    mreg_start = 1'b0;
    waitCnt = 0; reCyc = 0; gotDone = 1'b0;
    for (int k = 0; k < 40 && !gotDone; k++) begin
      bus.mem_rdy = (waitCnt == 2);
      bus.mem_rdata = mem.exists(int'(bus.mab)) ?
                      mem[int'(bus.mab)] : '0;
      #1;
      if (bus.mem_re) reCyc++;
      if (bus.mem_rdy) begin
        if (expQ.size() == 0 || idxQ.size() == 0) begin
          chk("pop extra", AW'(1), '0);
          expIdx = 4'd0;
          x = '{addr: '0, data: '0};
        end else begin
          x = expQ.pop_front();
          expIdx = idxQ.pop_front();
          chk("pop addr", bus.mab, x.addr);
        end
        if (mreg_done) gotDone = 1'b1;
        src_a = expIdx;
        tick();
        bus.mem_rdy = 1'b0;
        waitCnt = 0;
        chk($sformatf("pop r%0d", expIdx), rsrc, x.data);
      end else begin
        waitCnt++;
        tick();
      end
    end
    chk("pop done", AW'(gotDone), 20'h1);
    chk("pop re held", AW'(reCyc), 20'd9);
    chk("pop sp", sp, 20'h02400);
    chk("pop idle", AW'(mreg_busy), '0);

    bus.mem_rdy = 1'b0;
    mreg_start = 1'b1; mreg_pop = 1'b0;
    mreg_reg = 4'd4; mreg_cnt = 4'd0;
    tick();
    mreg_start = 1'b0;
    tick();
    chk("wr before rst", AW'(bus.mem_we), 20'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort we", AW'(bus.mem_we), '0);
    chk("abort busy", AW'(mreg_busy), '0);
    chk("abort sp", sp, 20'h02400);
    chk("abort pc", pc, 20'h04400);
`else
    bus.mem_rdy = 1'b1;
    mreg_start = 1'b1; mreg_pop = 1'b0;
    mreg_reg = 4'd10; mreg_cnt = 4'd2;
    tick();
    mreg_start = 1'b0;
    tick();
    chk("off busy", AW'(mreg_busy), '0);
    chk("off done", AW'(mreg_done), '0);
    chk("off we", AW'(bus.mem_we), '0);
    chk("off re", AW'(bus.mem_re), '0);
    chk("off wdata", bus.mem_wdata, '0);
    chk("off mab", bus.mab, '0);
    chk("off sp", sp, 20'h02400);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
